// File: rtl/config_loader_if.sv
// Host-side configuration word handshake for config_loader.
// master: bitstream source (drives cfg_data/cfg_valid, sees cfg_ready)
// slave : config_loader (accepts a word when cfg_valid && cfg_ready)
interface config_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/config_loader.sv
// config_loader: programming-chain master for an I/O bank configuration chain.
// Takes WORD_W-bit words from the host and shifts CHAIN_LEN bits, LSB first,
// into the chain, pulsing prog_en once per chain bit.
// Optional macro CONFIG_LOADER_READBACK_EN adds a VERIFY pass that recirculates
// the chain through prog_out and compares CRC-8 (poly 0x07) of both passes.
// Ports:
//   prog_clk, prog_rst : clock shared with the chain, sync active-high reset
//   start              : begin a load (sampled only when idle)
//   cfg (slave)        : cfg_data / cfg_valid / cfg_ready word handshake
//   prog_in, prog_en   : serial bit and shift enable to the chain head
//   prog_out           : serial bit from the chain tail
//   busy, done, error  : load in progress, completion pulse, readback mismatch
module config_loader #(
  parameter int CHAIN_LEN = 5,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic           prog_clk,
  input  logic           prog_rst,
  input  logic           start,
  config_loader_if.slave cfg,
  output logic           prog_in,
  output logic           prog_en,
  input  logic           prog_out,
  output logic           busy,
  output logic           done,
  output logic           error
);
  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = (CHAIN_LEN % WORD_W == 0) ? WORD_W : (CHAIN_LEN % WORD_W);
  localparam int WCNT_W    = $clog2(NWORDS + 1);
  localparam int SB_W      = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE, LOAD, DONE
`ifdef CONFIG_LOADER_READBACK_EN
    , VERIFY
`endif
  } state_t;

`ifdef CONFIG_LOADER_READBACK_EN
  localparam state_t LOAD_NEXT = VERIFY;
`else
  localparam state_t LOAD_NEXT = DONE;
`endif

  state_t            r_state;
  logic [WORD_W-1:0] r_hold, r_sreg, w_sreg_nxt;
  logic              r_hold_v;
  logic [SB_W-1:0]   r_hold_bits, r_sreg_bits, w_sreg_bits_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [WCNT_W-1:0] r_words;
  logic              r_prog_in, r_prog_en, r_busy, r_done;
  logic              w_ready, w_xfer, w_shift, w_bit, w_consume, w_last_word;

  assign w_ready       = (r_state == LOAD) && !r_hold_v && (r_words < WCNT_W'(NWORDS));
  assign cfg.cfg_ready = w_ready;
  assign w_xfer        = cfg.cfg_valid && w_ready;
  assign w_last_word   = (r_words == WCNT_W'(NWORDS - 1));

  // The bit source is sreg, or hold directly when sreg is empty, so a freshly
  // accepted word starts shifting on the cycle it reaches the front and the
  // refill from hold happens on the same edge as sreg's last bit.
  always_comb begin
    w_shift         = (r_state == LOAD) && ((r_sreg_bits != '0) || r_hold_v);
    w_bit           = (r_sreg_bits != '0) ? r_sreg[0] : r_hold[0];
    w_consume       = 1'b0;
    w_sreg_nxt      = r_sreg >> 1;
    w_sreg_bits_nxt = r_sreg_bits - SB_W'(1);
    if (r_sreg_bits == '0) begin
      w_consume       = 1'b1;
      w_sreg_nxt      = r_hold >> 1;
      w_sreg_bits_nxt = r_hold_bits - SB_W'(1);
    end else if ((r_sreg_bits == SB_W'(1)) && r_hold_v) begin
      w_consume       = 1'b1;
      w_sreg_nxt      = r_hold;
      w_sreg_bits_nxt = r_hold_bits;
    end
  end

`ifdef CONFIG_LOADER_READBACK_EN
  logic [7:0]       r_crc_load, r_crc_read, w_crc_read_nxt;
  logic [CNT_W-1:0] r_vcnt;
  logic             r_recirc, r_error;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  assign w_crc_read_nxt = r_recirc ? crc8(r_crc_read, prog_out) : r_crc_read;
  // During recirculation the tail bit is fed straight back to the head.
  assign prog_in = r_recirc ? prog_out : r_prog_in;
  assign error   = r_error;
`else
  logic w_unused_prog_out;
  assign w_unused_prog_out = prog_out;
  assign prog_in = r_prog_in;
  assign error   = 1'b0;
`endif

  assign prog_en = r_prog_en;
  assign busy    = r_busy;
  assign done    = r_done;

  always_ff @(posedge prog_clk) begin
    if (prog_rst) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_hold_v    <= 1'b0;
      r_hold_bits <= '0;
      r_sreg      <= '0;
      r_sreg_bits <= '0;
      r_bit_cnt   <= '0;
      r_words     <= '0;
      r_prog_in   <= 1'b0;
      r_prog_en   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef CONFIG_LOADER_READBACK_EN
      r_crc_load  <= '0;
      r_crc_read  <= '0;
      r_vcnt      <= '0;
      r_recirc    <= 1'b0;
      r_error     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state     <= LOAD;
          r_busy      <= 1'b1;
          r_bit_cnt   <= '0;
          r_words     <= '0;
          r_hold_v    <= 1'b0;
          r_sreg_bits <= '0;
`ifdef CONFIG_LOADER_READBACK_EN
          r_error     <= 1'b0;
          r_crc_load  <= '0;
          r_crc_read  <= '0;
          r_vcnt      <= '0;
`endif
        end
        LOAD: begin
          if (w_shift) begin
            r_prog_in   <= w_bit;
            r_prog_en   <= 1'b1;
            r_sreg      <= w_sreg_nxt;
            r_sreg_bits <= w_sreg_bits_nxt;
            r_bit_cnt   <= r_bit_cnt + CNT_W'(1);
            if (w_consume) r_hold_v <= 1'b0;
`ifdef CONFIG_LOADER_READBACK_EN
            r_crc_load  <= crc8(r_crc_load, w_bit);
`endif
            if (r_bit_cnt == CNT_W'(CHAIN_LEN - 1)) r_state <= LOAD_NEXT;
          end else begin
            r_prog_en <= 1'b0;
          end
          if (w_xfer) begin
            r_hold      <= cfg.cfg_data;
            r_hold_v    <= 1'b1;
            r_hold_bits <= w_last_word ? SB_W'(LAST_BITS) : SB_W'(WORD_W);
            r_words     <= r_words + WCNT_W'(1);
          end
        end
`ifdef CONFIG_LOADER_READBACK_EN
        // First VERIFY cycle still carries the last load bit; the following
        // CHAIN_LEN cycles recirculate and each sampled tail bit feeds crc_read.
        VERIFY: begin
          if (r_recirc) r_crc_read <= w_crc_read_nxt;
          if (r_vcnt == CNT_W'(CHAIN_LEN)) begin
            r_prog_en <= 1'b0;
            r_recirc  <= 1'b0;
            r_error   <= (r_crc_load != w_crc_read_nxt);
            r_state   <= DONE;
          end else begin
            r_prog_en <= 1'b1;
            r_recirc  <= 1'b1;
            r_vcnt    <= r_vcnt + CNT_W'(1);
          end
        end
`endif
        DONE: begin
          r_prog_en <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
